// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sharing of one 16-bit saturating add/sub unit
// between the ALU execute path (requester 0) and the auxiliary address path
// (requester 1). Owns the N/Z/V flag register, written only by requester 0.

module cla_16bit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             v_o
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] raw;
  logic             c_msb_in;
  logic             c_out;

  assign bx = b_i ^ {WIDTH{sub_i}};
  assign g  = a_i & bx;
  assign p  = a_i ^ bx;

  // Carry chain from generate/propagate terms; a scalar carry keeps the
  // combinational graph free of self-dependent vector bits.
  always_comb begin
    logic cy;
    cy       = sub_i;
    raw      = '0;
    c_msb_in = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      raw[i] = p[i] ^ cy;
      if (i == WIDTH - 1) c_msb_in = cy;
      cy = g[i] | (p[i] & cy);
    end
    c_out = cy;
  end

  // Clamp on signed overflow; the overflow direction follows the sign of a.
  always_comb begin
    v_o   = c_out ^ c_msb_in;
    sum_o = raw;
    if (v_o) sum_o = a_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
  end

endmodule

module addsub_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             req1_ready,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_v,
  output logic             res_n,
  output logic             res_z,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_v_q, res_v_d;
  logic             res_n_q, res_n_d;
  logic             res_z_q, res_z_d;
  logic             flag_n_q, flag_n_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_v_q, flag_v_d;
  logic             grant0, grant1;
  logic [WIDTH-1:0] alu_sum;
  logic             alu_v;

  cla_16bit #(.WIDTH(WIDTH)) u_cla (
    .a_i   (a_q),
    .b_i   (b_q),
    .sub_i (sub_q),
    .sum_o (alu_sum),
    .v_o   (alu_v)
  );

  // Round-robin grant in IDLE: on a tie the requester not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == S_IDLE) begin
      grant0 = req0_valid && (!req1_valid || last_q);
      grant1 = req1_valid && (!req0_valid || !last_q);
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign resp0_valid = (state_q == S_RESP) && !owner_q;
  assign resp1_valid = (state_q == S_RESP) && owner_q;
  assign res_sum     = res_sum_q;
  assign res_v       = res_v_q;
  assign res_n       = res_n_q;
  assign res_z       = res_z_q;
  assign flag_n      = flag_n_q;
  assign flag_z      = flag_z_q;
  assign flag_v      = flag_v_q;

  // Next state: latch operands on accept, capture result at end of EXEC.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    res_sum_d = res_sum_q;
    res_v_d   = res_v_q;
    res_n_d   = res_n_q;
    res_z_d   = res_z_q;
    flag_n_d  = flag_n_q;
    flag_z_d  = flag_z_q;
    flag_v_d  = flag_v_q;
    case (state_q)
      S_IDLE: begin
        if (grant0 || grant1) begin
          state_d = S_EXEC;
          owner_d = grant1;
          last_d  = grant1;
          a_d     = grant1 ? req1_a   : req0_a;
          b_d     = grant1 ? req1_b   : req0_b;
          sub_d   = grant1 ? req1_sub : req0_sub;
        end
      end
      S_EXEC: begin
        state_d   = S_RESP;
        res_sum_d = alu_sum;
        res_v_d   = alu_v;
        res_n_d   = alu_sum[WIDTH-1];
        res_z_d   = (alu_sum == '0);
        if (!owner_q) begin
          flag_n_d = alu_sum[WIDTH-1];
          flag_z_d = (alu_sum == '0);
          flag_v_d = alu_v;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      res_sum_q <= '0;
      res_v_q   <= 1'b0;
      res_n_q   <= 1'b0;
      res_z_q   <= 1'b0;
      flag_n_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_v_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sub_q     <= sub_d;
      res_sum_q <= res_sum_d;
      res_v_q   <= res_v_d;
      res_n_q   <= res_n_d;
      res_z_q   <= res_z_d;
      flag_n_q  <= flag_n_d;
      flag_z_q  <= flag_z_d;
      flag_v_q  <= flag_v_d;
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with hand-computed expected results.

module tb_addsub_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic [15:0] req0_a = '0;
  logic [15:0] req0_b = '0;
  logic        req0_sub = 1'b0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [15:0] req1_a = '0;
  logic [15:0] req1_b = '0;
  logic        req1_sub = 1'b0;
  logic        req1_ready;
  logic        resp0_valid, resp1_valid;
  logic [15:0] res_sum;
  logic        res_v, res_n, res_z;
  logic        flag_n, flag_z, flag_v;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  addsub_arbiter #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_sub    (req0_sub),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_sub    (req1_sub),
    .req1_ready  (req1_ready),
    .resp0_valid (resp0_valid),
    .resp1_valid (resp1_valid),
    .res_sum     (res_sum),
    .res_v       (res_v),
    .res_n       (res_n),
    .res_z       (res_z),
    .flag_n      (flag_n),
    .flag_z      (flag_z),
    .flag_v      (flag_v)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one op from requester r starting at posedge+1 in IDLE, returns
  // what was observed; returns at posedge+1 of the cycle after the response.
  task automatic run_op(input logic r, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, output logic acc, output int unsigned acc_cyc,
                        output logic got, output int unsigned lat,
                        output logic [15:0] s, output logic v, output logic n,
                        output logic z);
    acc = 1'b0; acc_cyc = 0; got = 1'b0; lat = 0;
    s = '0; v = 1'b0; n = 1'b0; z = 1'b0;
    if (r) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (r ? req1_ready : req0_ready) begin
        acc = 1'b1; acc_cyc = i;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (r) req1_valid = 1'b0; else req0_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!got && (r ? resp1_valid : resp0_valid)) begin
        got = 1'b1; lat = i;
        s = res_sum; v = res_v; n = res_n; z = res_z;
      end
      @(posedge clk); #1;
      if (got) break;
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({res_sum, res_v, res_n, res_z, flag_n, flag_z, flag_v, resp0_valid,
         resp1_valid, req0_ready, req1_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got sum=%h v%b n%b z%b flags=%b%b%b resp=%b%b, required all zero",
               res_sum, res_v, res_n, res_z, flag_n, flag_z, flag_v, resp0_valid, resp1_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic acc, got, v, n, z;
    int unsigned ac, lat;
    logic [15:0] s;
    run_op(1'b0, 16'd20000, 16'd10000, 1'b0, acc, ac, got, lat, s, v, n, z);
    n_checks++;
    if ({acc, got} !== 2'b11 || ac != 0 || lat != 1) begin
      n_fail++;
      $display("FAIL add_timing: got acc=%b cyc=%0d resp=%b lat=%0d, required 1/0/1/1", acc, ac, got, lat);
    end
    n_checks++;
    if ({s, v, n, z} !== {16'd30000, 3'b000}) begin
      n_fail++;
      $display("FAIL add_result: got %h v%b n%b z%b, required 7530 v0 n0 z0", s, v, n, z);
    end
    n_checks++;
    if ({flag_n, flag_z, flag_v} !== 3'b000 || resp0_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_flags: got nzv=%b%b%b resp0=%b, required 000 resp0=0", flag_n, flag_z, flag_v, resp0_valid);
    end
  endtask

  task automatic test_saturation();
    logic acc, got, v, n, z;
    int unsigned ac, lat;
    logic [15:0] s;
    run_op(1'b0, 16'h7FFF, 16'd100, 1'b0, acc, ac, got, lat, s, v, n, z);
    n_checks++;
    if ({got, s, v, n, z} !== {1'b1, 16'h7FFF, 3'b100} || flag_v !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_pos_add: got %h v%b n%b z%b flag_v%b, required 7fff v1 n0 z0 flag_v1", s, v, n, z, flag_v);
    end
    run_op(1'b0, 16'h8001, 16'hFB2E, 1'b0, acc, ac, got, lat, s, v, n, z);
    n_checks++;
    if ({got, s, v, n, z} !== {1'b1, 16'h8000, 3'b110}) begin
      n_fail++;
      $display("FAIL sat_neg_add: got %h v%b n%b z%b, required 8000 v1 n1 z0", s, v, n, z);
    end
    n_checks++;
    if ({flag_n, flag_z, flag_v} !== 3'b101) begin
      n_fail++;
      $display("FAIL sat_neg_flags: got nzv=%b%b%b, required 101", flag_n, flag_z, flag_v);
    end
    run_op(1'b0, 16'h8000, 16'h0001, 1'b1, acc, ac, got, lat, s, v, n, z);
    n_checks++;
    if ({got, s, v, n, z} !== {1'b1, 16'h8000, 3'b110}) begin
      n_fail++;
      $display("FAIL sat_neg_sub: got %h v%b n%b z%b, required 8000 v1 n1 z0", s, v, n, z);
    end
    run_op(1'b0, 16'h7FFF, 16'hFFFF, 1'b1, acc, ac, got, lat, s, v, n, z);
    n_checks++;
    if ({got, s, v, n, z} !== {1'b1, 16'h7FFF, 3'b100} || {flag_n, flag_z, flag_v} !== 3'b001) begin
      n_fail++;
      $display("FAIL sat_pos_sub: got %h v%b n%b z%b flags=%b%b%b, required 7fff v1 n0 z0 flags 001",
               s, v, n, z, flag_n, flag_z, flag_v);
    end
  endtask

  task automatic test_req1_sub();
    logic acc, got, v, n, z;
    int unsigned ac, lat;
    logic [15:0] s;
    run_op(1'b1, 16'd20000, 16'd10000, 1'b1, acc, ac, got, lat, s, v, n, z);
    n_checks++;
    if ({acc, got} !== 2'b11 || lat != 1 || {s, v, n, z} !== {16'd10000, 3'b000}) begin
      n_fail++;
      $display("FAIL r1_sub: got acc=%b resp=%b lat=%0d %h v%b n%b z%b, required 2710 v0 n0 z0", acc, got, lat, s, v, n, z);
    end
    run_op(1'b1, 16'd5, 16'd5, 1'b1, acc, ac, got, lat, s, v, n, z);
    n_checks++;
    if ({got, s, v, n, z} !== {1'b1, 16'h0000, 3'b001}) begin
      n_fail++;
      $display("FAIL r1_zero: got %h v%b n%b z%b, required 0000 v0 n0 z1", s, v, n, z);
    end
    n_checks++;
    if ({flag_n, flag_z, flag_v} !== 3'b001) begin
      n_fail++;
      $display("FAIL r1_flags_kept: got nzv=%b%b%b, required 001", flag_n, flag_z, flag_v);
    end
  endtask

  task automatic test_arbitration();
    logic        ord[8];
    int unsigned tim[8];
    int unsigned n_acc, n_resp;
    logic        both;
    n_acc = 0; n_resp = 0; both = 1'b0;
    rst = 1'b1; #1;
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 16'd100; req0_b = 16'd1;  req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 16'd300; req1_b = 16'd50; req1_sub = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) both = 1'b1;
      if ((req0_ready || req1_ready) && n_acc < 8) begin
        ord[n_acc] = req1_ready; tim[n_acc] = c; n_acc++;
      end
      if (resp0_valid) begin
        n_resp++; n_checks++;
        if (res_sum !== 16'd101 || resp1_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL arb_resp0 @%0d: got %h resp1=%b, required 0065 resp1=0", c, res_sum, resp1_valid);
        end
      end
      if (resp1_valid) begin
        n_resp++; n_checks++;
        if (res_sum !== 16'd250) begin
          n_fail++;
          $display("FAIL arb_resp1 @%0d: got %h, required 00fa", c, res_sum);
        end
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++;
    if (n_acc != 4 || n_resp != 4 || both) begin
      n_fail++;
      $display("FAIL arb_counts: got accepts=%0d resps=%0d dual_ready=%b, required 4 4 0", n_acc, n_resp, both);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < int'(n_acc)) begin
        n_checks++;
        if (ord[i] !== 1'(i % 2) || tim[i] != 3 * i) begin
          n_fail++;
          $display("FAIL arb_order[%0d]: got req%0d at cycle %0d, required req%0d at cycle %0d",
                   i, ord[i], tim[i], i % 2, 3 * i);
        end
      end
    end
  endtask

  task automatic test_hold_cancel();
    logic acc, got, v, n, z, seen;
    int unsigned ac, lat;
    logic [15:0] s;
    req0_valid = 1'b1; req0_a = 16'd1; req0_b = 16'd2; req0_sub = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_accept0: got ready0=%b, required 1", req0_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 16'd11; req1_b = 16'd22; req1_sub = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_exec_ready1: got %b, required 0", req1_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (req1_ready !== 1'b0 || resp0_valid !== 1'b1 || res_sum !== 16'd3) begin
      n_fail++;
      $display("FAIL hold_resp_ready1: got ready1=%b resp0=%b sum=%h, required 0 1 0003", req1_ready, resp0_valid, res_sum);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp1_valid || req1_ready) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen !== 1'b0 || res_sum !== 16'd3) begin
      n_fail++;
      $display("FAIL cancel_no_resp: got activity=%b sum=%h, required 0 0003", seen, res_sum);
    end
    run_op(1'b1, 16'd11, 16'd22, 1'b0, acc, ac, got, lat, s, v, n, z);
    n_checks++;
    if ({acc, got} !== 2'b11 || s !== 16'd33) begin
      n_fail++;
      $display("FAIL cancel_retry: got acc=%b resp=%b sum=%h, required 1 1 0021", acc, got, s);
    end
  endtask

  task automatic test_reset_mid_op();
    logic acc, got, v, n, z;
    int unsigned ac, lat;
    logic [15:0] s;
    run_op(1'b0, 16'h7FFF, 16'd1, 1'b0, acc, ac, got, lat, s, v, n, z);
    n_checks++;
    if ({s, flag_v} !== {16'h7FFF, 1'b1}) begin
      n_fail++;
      $display("FAIL rstmid_setup: got %h flag_v%b, required 7fff 1", s, flag_v);
    end
    req0_valid = 1'b1; req0_a = 16'hFFFB; req0_b = 16'd3; req0_sub = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({res_sum, res_v, res_n, res_z, flag_n, flag_z, flag_v, resp0_valid, resp1_valid} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: got sum=%h v%b n%b z%b flags=%b%b%b resp=%b%b, required all zero",
               res_sum, res_v, res_n, res_z, flag_n, flag_z, flag_v, resp0_valid, resp1_valid);
    end
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 16'd7; req0_b = 16'd2; req0_sub = 1'b1;
    req1_valid = 1'b1; req1_a = 16'd9; req1_b = 16'd9; req1_sub = 1'b0;
    @(negedge clk);
    n_checks++;
    if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_no_resp: got resp=%b%b, required 00", resp0_valid, resp1_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_first_grant: got ready=%b%b, required 10", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (resp0_valid !== 1'b1 || res_sum !== 16'd5) begin
      n_fail++;
      $display("FAIL rstmid_after: got resp0=%b sum=%h, required 1 0005", resp0_valid, res_sum);
    end
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (req1_ready) begin
        @(posedge clk); #1;
        req1_valid = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_saturation();
    test_req1_sub();
    test_arbitration();
    test_hold_cancel();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
